// File: rtl/card_mem_arbiter.sv
// Write-port arbiter for the card-state memory: game-write queue, colour
// initialiser stream and a full-memory clear sweep share one registered port.
module card_mem_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_req,
  output logic               clear_done,
  input  logic               wr_en,
  input  logic [1:0]         wr_state,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic               init_valid,
  output logic               init_ready,
  input  logic [ADDR_W-1:0]  init_addr,
  input  logic [COLOR_W-1:0] init_color,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [1:0]         mem_state,
  output logic [COLOR_W-1:0] mem_color,
  output logic               mem_state_mask,
  output logic               mem_color_mask,
  output logic               busy,
  output logic               overflow
);

  localparam int QW = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} fsm_t;

  fsm_t                   fsm_reg;
  logic [ADDR_W-1:0]      sweep_reg;
  logic [1:0]             count_reg;
  logic [1:0]             count_next;
  logic [1:0]             count_after;
  logic [1:0][QW-1:0]     q_cur;
  logic [1:0][QW-1:0]     q_next;
  logic                   pop;
  logic                   drop;
  logic                   clear_done_reg;
  logic                   overflow_reg;
  logic                   mem_we_reg;
  logic [ADDR_W-1:0]      mem_addr_reg;
  logic [1:0]             mem_state_reg;
  logic [COLOR_W-1:0]     mem_color_reg;
  logic                   mem_state_mask_reg;
  logic                   mem_color_mask_reg;

  // Queue head is popped only from IDLE and only when no clear is starting.
  assign pop = (fsm_reg == IDLE) && !clear_req && (count_reg != 2'd0);
  assign count_after = count_reg - 2'(pop);

  always_comb begin
    q_next     = q_cur;
    count_next = count_after;
    drop       = 1'b0;
    if (pop) begin
      q_next[0] = q_cur[1];
    end
    if (wr_en) begin
      if (count_after == 2'd2) begin
        drop = 1'b1;
      end else begin
        q_next[count_after[0]] = {wr_state, wr_addr};
        count_next             = count_after + 2'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [QW-1:0] slot_reg;
      always_ff @(posedge clk) begin
        if (rst) slot_reg <= '0;
        else     slot_reg <= q_next[gi];
      end
      assign q_cur[gi] = slot_reg;
    end
  endgenerate

  assign init_ready = (fsm_reg == IDLE) && (count_reg == 2'd0) && !wr_en && !clear_req;
  assign busy       = (fsm_reg == CLEAR) || (count_reg != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg            <= IDLE;
      sweep_reg          <= '0;
      count_reg          <= '0;
      overflow_reg       <= 1'b0;
      clear_done_reg     <= 1'b0;
      mem_we_reg         <= 1'b0;
      mem_addr_reg       <= '0;
      mem_state_reg      <= '0;
      mem_color_reg      <= '0;
      mem_state_mask_reg <= 1'b0;
      mem_color_mask_reg <= 1'b0;
    end else begin
      count_reg          <= count_next;
      mem_we_reg         <= 1'b0;
      clear_done_reg     <= 1'b0;
      mem_state_mask_reg <= 1'b0;
      mem_color_mask_reg <= 1'b0;
      if (drop) overflow_reg <= 1'b1;
      case (fsm_reg)
        IDLE: begin
          if (clear_req) begin
            fsm_reg   <= CLEAR;
            sweep_reg <= '0;
          end else if (pop) begin
            mem_we_reg         <= 1'b1;
            mem_addr_reg       <= q_cur[0][ADDR_W-1:0];
            mem_state_reg      <= q_cur[0][QW-1:ADDR_W];
            mem_color_reg      <= '0;
            mem_state_mask_reg <= 1'b1;
          end else if (init_valid && init_ready) begin
            mem_we_reg         <= 1'b1;
            mem_addr_reg       <= init_addr;
            mem_state_reg      <= 2'b00;
            mem_color_reg      <= init_color;
            mem_state_mask_reg <= 1'b1;
            mem_color_mask_reg <= 1'b1;
          end
        end
        CLEAR: begin
          mem_we_reg         <= 1'b1;
          mem_addr_reg       <= sweep_reg;
          mem_state_reg      <= 2'b00;
          mem_color_reg      <= '0;
          mem_state_mask_reg <= 1'b1;
          mem_color_mask_reg <= 1'b1;
          // Done pulse is registered alongside the final sweep write.
          if (sweep_reg == LAST_ADDR) begin
            clear_done_reg <= 1'b1;
            sweep_reg      <= '0;
            fsm_reg        <= IDLE;
          end else begin
            sweep_reg <= sweep_reg + 1'b1;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign clear_done     = clear_done_reg;
  assign overflow       = overflow_reg;
  assign mem_we         = mem_we_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_state      = mem_state_reg;
  assign mem_color      = mem_color_reg;
  assign mem_state_mask = mem_state_mask_reg;
  assign mem_color_mask = mem_color_mask_reg;

endmodule

// File: tb/tb_card_mem_arbiter.sv
// Scoreboard bench for card_mem_arbiter: a queue-based reference model predicts
// each memory write; a monitor pops and compares whenever mem_we is seen.
module tb_card_mem_arbiter;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_req = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_state = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          init_valid = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [CW-1:0] init_color = '0;
  logic          clear_done, init_ready, mem_we, mem_state_mask, mem_color_mask;
  logic          busy, overflow;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_state;
  logic [CW-1:0] mem_color;

  card_mem_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .COLOR_W(CW)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_done(clear_done),
    .wr_en(wr_en), .wr_state(wr_state), .wr_addr(wr_addr),
    .init_valid(init_valid), .init_ready(init_ready), .init_addr(init_addr),
    .init_color(init_color), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_state(mem_state), .mem_color(mem_color),
    .mem_state_mask(mem_state_mask), .mem_color_mask(mem_color_mask),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr; int st; int col; int sm; int cm; int done; int cyc;
  } wr_t;
  typedef struct {
    int st; int addr;
  } gw_t;

  wr_t exp_q[$];
  gw_t gq[$];
  bit  m_clear = 0;
  int  m_sweep = 0;
  bit  m_ovf = 0;
  bit  m_xfer = 0;
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  wr_t mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int a, input int s, input int c, input int sm, input int cm,
                          input int d);
    wr_t e;
    e.addr = a; e.st = s; e.col = c; e.sm = sm; e.cm = cm; e.done = d; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  // One clock cycle: inputs already set; model decides what the arbiter does.
  task automatic step();
    bit  ready;
    gw_t h;
    gw_t w;
    #1;
    m_xfer = 0;
    if (rst) begin
      gq.delete();
      m_clear = 0;
      m_sweep = 0;
      m_ovf   = 0;
    end else begin
      chk("busy", busy, (m_clear || gq.size() > 0) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
      ready = !m_clear && gq.size() == 0 && !wr_en && !clear_req;
      chk("init_ready", init_ready, ready);
      if (m_clear) begin
        push_exp(m_sweep, 0, 0, 1, 1, (m_sweep == DEPTH - 1) ? 1 : 0);
        if (m_sweep == DEPTH - 1) begin
          m_clear = 0;
          m_sweep = 0;
        end else begin
          m_sweep++;
        end
      end else if (clear_req) begin
        m_clear = 1;
        m_sweep = 0;
      end else if (gq.size() > 0) begin
        h = gq.pop_front();
        push_exp(h.addr, h.st, 0, 1, 0, 0);
      end else if (init_valid && ready) begin
        push_exp(int'(init_addr), 0, int'(init_color), 1, 1, 0);
        m_xfer = 1;
      end
      if (wr_en) begin
        if (gq.size() < 2) begin
          w.st = int'(wr_state);
          w.addr = int'(wr_addr);
          gq.push_back(w);
        end else begin
          m_ovf = 1;
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_write cyc=%0d want_addr=%0d want_cyc=%0d", cyc, mon_e.addr, mon_e.cyc);
    end
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write cyc=%0d got_addr=%0d want=no_write", cyc, mem_addr);
      end else begin
        mon_e = exp_q.pop_front();
        $display("write cyc=%0d addr=%0d state=%0d color=%03h masks=%0d%0d done=%0d",
                 cyc, mem_addr, mem_state, mem_color, mem_state_mask, mem_color_mask, clear_done);
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("mem_addr", mem_addr, mon_e.addr);
        chk("mem_state", mem_state, mon_e.st);
        chk("mem_color", mem_color, mon_e.col);
        chk("state_mask", mem_state_mask, mon_e.sm);
        chk("color_mask", mem_color_mask, mon_e.cm);
        chk("clear_done", clear_done, mon_e.done);
      end
    end else begin
      chk("clear_done_idle", clear_done, 0);
    end
  end

  initial begin
    int idx;
    int guard;
    bit fired;
    @(negedge clk);
    #1;
    repeat (3) step();
    // Reset state of all registered outputs.
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_state", mem_state, 0);
    chk("rst_mem_color", mem_color, 0);
    chk("rst_smask", mem_state_mask, 0);
    chk("rst_cmask", mem_color_mask, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Single game write.
    wr_en = 1; wr_addr = 3; wr_state = 2'b11; step();
    wr_en = 0; repeat (3) step();

    // Back-to-back game writes.
    wr_en = 1; wr_addr = 2; wr_state = 2'b01; step();
    wr_addr = 5; step();
    wr_en = 0; repeat (3) step();

    // Plain clear sweep.
    clear_req = 1; step();
    clear_req = 0; repeat (18) step();

    // Three game writes during a sweep: third one overflows.
    clear_req = 1; step();
    clear_req = 0;
    for (int a = 7; a <= 9; a++) begin
      wr_en = 1; wr_addr = AW'(a); wr_state = 2'b01; step();
    end
    wr_en = 0; repeat (20) step();
    chk("overflow_sticky", overflow, 1);
    rst = 1; step(); rst = 0; step();

    // Init stream of 12 words with one game write at word 4.
    idx = 0; guard = 0; fired = 0;
    while (idx < 12 && guard < 100) begin
      init_valid = 1;
      init_addr  = AW'(idx);
      init_color = CW'((12'hF00 >> (4 * (idx % 3))) ^ idx);
      wr_en      = (idx == 4 && !fired);
      wr_addr    = 4'd13;
      wr_state   = 2'b10;
      if (wr_en) fired = 1;
      step();
      if (m_xfer) idx++;
      guard++;
    end
    chk("init_words", idx, 12);
    init_valid = 0; wr_en = 0; repeat (3) step();

    // Reset in the middle of a sweep.
    clear_req = 1; step(); clear_req = 0;
    guard = 0;
    while (m_sweep != 6 && guard < 40) begin
      step();
      guard++;
    end
    rst = 1; step(); rst = 0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we", mem_we, 0);
    repeat (3) step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      clear_req  = ($urandom_range(0, 39) == 0);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_state   = 2'($urandom);
      wr_addr    = AW'($urandom);
      init_valid = 1'($urandom);
      init_addr  = AW'($urandom);
      init_color = CW'($urandom);
      step();
    end
    rst = 0; clear_req = 0; wr_en = 0; init_valid = 0;
    repeat (25) step();
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
